// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for a RED->GREEN->YELLOW traffic-light controller.
// Checks one-hot lights, phase order and exact enabled-cycle dwell per phase.
module traffic_light_monitor #(
    parameter int RED_CYCLES    = 8,
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err_pulse,
    output logic [3:0]       err_flags,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] cycles_done
);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        EC_NONE        = 3'd0,
        EC_ONEHOT      = 3'd1,
        EC_HOLD        = 3'd2,
        EC_ORDER       = 3'd3,
        EC_DWELL_SHORT = 3'd4,
        EC_DWELL_LONG  = 3'd5
    } err_code_t;

    localparam logic [CNT_W-1:0] RED_LIM    = CNT_W'(RED_CYCLES);
    localparam logic [CNT_W-1:0] GREEN_LIM  = CNT_W'(GREEN_CYCLES);
    localparam logic [CNT_W-1:0] YELLOW_LIM = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_n;
    phase_t           phase_q, phase_n;
    logic [CNT_W-1:0] dwell_q, dwell_n;
    logic             reported_q, reported_n;   // dwell_long already raised in this occurrence
    logic             phase_bad_q, phase_bad_n; // any violation during this occurrence

    phase_t           light_ph;
    logic             light_valid;
    logic             light_multi;
    logic [CNT_W-1:0] cur_lim;
    phase_t           succ_ph;
    logic [CNT_W-1:0] dwell_inc;
    err_code_t        viol;
    logic             cycle_inc;
    logic [3:0]       flags_n;
    logic [2:0]       code_n;

    // Light vector decode: exactly one lamp maps to a phase, anything else is PH_NONE.
    always_comb begin
        light_ph = PH_NONE;
        unique case ({red, yellow, green})
            3'b100:  light_ph = PH_RED;
            3'b001:  light_ph = PH_GREEN;
            3'b010:  light_ph = PH_YELLOW;
            default: light_ph = PH_NONE;
        endcase
    end

    assign light_valid = (light_ph != PH_NONE);
    assign light_multi = (red & yellow) | (red & green) | (yellow & green);

    always_comb begin
        cur_lim = '0;
        succ_ph = PH_NONE;
        unique case (phase_q)
            PH_RED: begin
                cur_lim = RED_LIM;
                succ_ph = PH_GREEN;
            end
            PH_GREEN: begin
                cur_lim = GREEN_LIM;
                succ_ph = PH_YELLOW;
            end
            PH_YELLOW: begin
                cur_lim = YELLOW_LIM;
                succ_ph = PH_RED;
            end
            default: begin
                cur_lim = '0;
                succ_ph = PH_NONE;
            end
        endcase
    end

    assign dwell_inc = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + CNT_ONE;

    // Next-state and violation classification; priority onehot > hold > order > dwell.
    always_comb begin
        state_n     = state_q;
        phase_n     = phase_q;
        dwell_n     = dwell_q;
        reported_n  = reported_q;
        phase_bad_n = phase_bad_q;
        viol        = EC_NONE;
        cycle_inc   = 1'b0;

        unique case (state_q)
            ST_SYNC: begin
                if (light_ph == PH_RED) begin
                    state_n     = ST_RUN;
                    phase_n     = PH_RED;
                    dwell_n     = enable ? CNT_ONE : '0;
                    reported_n  = 1'b0;
                    phase_bad_n = 1'b0;
                end else if (light_multi) begin
                    viol = EC_ONEHOT;
                end
            end

            ST_RUN: begin
                if (!light_valid) begin
                    viol        = EC_ONEHOT;
                    state_n     = ST_SYNC;
                    phase_n     = PH_NONE;
                    dwell_n     = '0;
                    reported_n  = 1'b0;
                    phase_bad_n = 1'b0;
                end else if (light_ph == phase_q) begin
                    if (enable) begin
                        dwell_n = dwell_inc;
                        if ((dwell_inc > cur_lim) && !reported_q) begin
                            viol        = EC_DWELL_LONG;
                            reported_n  = 1'b1;
                            phase_bad_n = 1'b1;
                        end
                    end
                end else if (!enable) begin
                    viol        = EC_HOLD;
                    phase_n     = light_ph;
                    dwell_n     = '0;
                    reported_n  = 1'b0;
                    phase_bad_n = 1'b1;
                end else if (light_ph != succ_ph) begin
                    viol        = EC_ORDER;
                    phase_n     = light_ph;
                    dwell_n     = CNT_ONE;
                    reported_n  = 1'b0;
                    phase_bad_n = 1'b1;
                end else begin
                    // Legal successor: an early exit is dwell_short and also spoils the
                    // new occurrence, so a short YELLOW never counts as a finished cycle.
                    if (dwell_q < cur_lim) begin
                        viol = EC_DWELL_SHORT;
                    end
                    cycle_inc   = (phase_q == PH_YELLOW) && !phase_bad_q && (dwell_q >= cur_lim);
                    phase_n     = light_ph;
                    dwell_n     = CNT_ONE;
                    reported_n  = 1'b0;
                    phase_bad_n = (dwell_q < cur_lim);
                end
            end

            default: begin
                state_n = ST_SYNC;
                phase_n = PH_NONE;
            end
        endcase
    end

    // A violation on the same edge as clr_err survives the clear.
    always_comb begin
        flags_n = clr_err ? 4'b0000 : err_flags;
        code_n  = clr_err ? 3'd0 : err_code;
        if (viol != EC_NONE) begin
            code_n = viol;
            unique case (viol)
                EC_ONEHOT:      flags_n[0] = 1'b1;
                EC_HOLD:        flags_n[1] = 1'b1;
                EC_ORDER:       flags_n[2] = 1'b1;
                EC_DWELL_SHORT: flags_n[3] = 1'b1;
                EC_DWELL_LONG:  flags_n[3] = 1'b1;
                default:        flags_n    = flags_n;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            phase_q     <= PH_NONE;
            dwell_q     <= '0;
            reported_q  <= 1'b0;
            phase_bad_q <= 1'b0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_flags   <= 4'b0000;
            err_code    <= 3'd0;
            cycles_done <= '0;
        end else begin
            state_q     <= state_n;
            phase_q     <= phase_n;
            dwell_q     <= dwell_n;
            reported_q  <= reported_n;
            phase_bad_q <= phase_bad_n;
            locked      <= (state_n == ST_RUN);
            err_pulse   <= (viol != EC_NONE);
            err_flags   <= flags_n;
            err_code    <= code_n;
            cycles_done <= cycles_done + CNT_W'(cycle_inc);
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random light traffic,
// every cycle compared against a behavioural model of the checking rules.
module tb_traffic_light_monitor;

    localparam int RED_N    = 8;
    localparam int GREEN_N  = 8;
    localparam int YELLOW_N = 3;
    localparam int CNT_W    = 8;
    localparam int OUT_W    = 2 + 1 + 1 + 4 + 3 + CNT_W;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_GREEN  = 3'b001;
    localparam logic [2:0] L_YELLOW = 3'b010;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             red;
    logic             yellow;
    logic             green;
    logic             clr_err;
    logic [1:0]       phase;
    logic             locked;
    logic             err_pulse;
    logic [3:0]       err_flags;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] cycles_done;

    traffic_light_monitor #(
        .RED_CYCLES   (RED_N),
        .GREEN_CYCLES (GREEN_N),
        .YELLOW_CYCLES(YELLOW_N),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .clr_err    (clr_err),
        .phase      (phase),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_flags  (err_flags),
        .err_code   (err_code),
        .cycles_done(cycles_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    logic [OUT_W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the phase occurrence in plain integers: which phase, how many enabled
    // samples it has lasted, whether dwell_long was already raised, whether it was spoiled.
    int m_run, m_ph, m_cnt, m_long_done, m_occ_bad;
    int m_cycles, m_flags, m_code;
    int flag_bit_of[6] = '{0, 0, 1, 2, 3, 3};

    function automatic int lim_of(input int p);
        case (p)
            1:       return RED_N;
            2:       return GREEN_N;
            3:       return YELLOW_N;
            default: return 0;
        endcase
    endfunction

    function automatic int next_of(input int p);
        return (p == 3) ? 1 : p + 1;
    endfunction

    function automatic int decode(input logic [2:0] l);
        if (l == L_RED)    return 1;
        if (l == L_GREEN)  return 2;
        if (l == L_YELLOW) return 3;
        return 0;
    endfunction

    task automatic model_step(input logic [2:0] l, input logic en, input logic clr, input logic rst);
        int code;
        int lp;
        int ones;
        int old;
        bit legal;
        code = 0;
        lp   = decode(l);
        ones = int'(l[2]) + int'(l[1]) + int'(l[0]);
        if (rst) begin
            m_run = 0; m_ph = 0; m_cnt = 0; m_long_done = 0; m_occ_bad = 0;
            m_cycles = 0; m_flags = 0; m_code = 0;
            exp_q.push_back('0);
            return;
        end
        if (m_run == 0) begin
            if (lp == 1) begin
                m_run = 1; m_ph = 1; m_cnt = en ? 1 : 0; m_long_done = 0; m_occ_bad = 0;
            end else if (ones > 1) begin
                code = 1;
            end
        end else if (ones != 1) begin
            code = 1;
            m_run = 0; m_ph = 0; m_cnt = 0;
        end else if (lp == m_ph) begin
            if (en) begin
                m_cnt++;
                if (m_cnt > lim_of(m_ph) && m_long_done == 0) begin
                    code = 5; m_long_done = 1; m_occ_bad = 1;
                end
            end
        end else begin
            old   = m_ph;
            legal = en && (lp == next_of(old));
            if (!en)                        code = 2;
            else if (!legal)                code = 3;
            else if (m_cnt < lim_of(old))   code = 4;
            if (legal && old == 3 && code == 0 && m_occ_bad == 0)
                m_cycles = (m_cycles + 1) % (1 << CNT_W);
            m_ph = lp;
            m_cnt = en ? 1 : 0;
            m_long_done = 0;
            m_occ_bad = (code != 0) ? 1 : 0;
        end
        if (clr) begin
            m_flags = 0;
            m_code  = 0;
        end
        if (code != 0) begin
            m_flags = m_flags | (1 << flag_bit_of[code]);
            m_code  = code;
        end
        exp_q.push_back({2'(m_ph), 1'(m_run), 1'(code != 0), 4'(m_flags), 3'(m_code), CNT_W'(m_cycles)});
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [2:0] l, input logic en, input logic clr, input logic rst);
        logic [OUT_W-1:0] exp_word;
        {red, yellow, green} = l;
        enable  = en;
        clr_err = clr;
        reset   = rst;
        @(posedge clk);
        #1;
        model_step(l, en, clr, rst);
        exp_word = exp_q.pop_front();
        check_val("outs", {phase, locked, err_pulse, err_flags, err_code, cycles_done}, exp_word);
        pulse_cnt += int'(err_pulse);
    endtask

    task automatic drive_n(input logic [2:0] l, input logic en, input int n);
        for (int i = 0; i < n; i++) step(l, en, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(3'b000, 1'b1, 1'b0, 1'b1);
    endtask

    function automatic logic [2:0] succ_l(input logic [2:0] l);
        if (l == L_RED)   return L_GREEN;
        if (l == L_GREEN) return L_YELLOW;
        return L_RED;
    endfunction

    function automatic int lim_l(input logic [2:0] l);
        return lim_of(decode(l));
    endfunction

    // ---------------- stimulus ----------------
    logic [2:0] cur_l;
    logic [2:0] rl;
    logic       ren, rclr, rrst;
    int         remain;
    int         pick;

    initial begin
        reset = 1'b1; enable = 1'b1; red = 1'b0; yellow = 1'b0; green = 1'b0; clr_err = 1'b0;
        m_run = 0; m_ph = 0; m_cnt = 0; m_long_done = 0; m_occ_bad = 0;
        m_cycles = 0; m_flags = 0; m_code = 0;

        // Legal full cycle
        do_reset();
        do_reset();
        check_val("rst_state", {phase, locked, err_pulse, err_flags, err_code, cycles_done}, 0);
        pulse_cnt = 0;
        step(L_RED, 1'b1, 1'b0, 1'b0);
        check_val("lock_first_red", {phase, locked}, {2'd1, 1'b1});
        drive_n(L_RED, 1'b1, 7);
        step(L_GREEN, 1'b1, 1'b0, 1'b0);
        check_val("phase_green", phase, 2);
        drive_n(L_GREEN, 1'b1, 7);
        step(L_YELLOW, 1'b1, 1'b0, 1'b0);
        check_val("phase_yellow", phase, 3);
        drive_n(L_YELLOW, 1'b1, 2);
        step(L_RED, 1'b1, 1'b0, 1'b0);
        check_val("cycle_count_1", cycles_done, 1);
        check_val("legal_no_pulse", pulse_cnt, 0);
        check_val("legal_phase_red", phase, 1);

        // Short RED -> dwell_short
        drive_n(L_RED, 1'b1, 4);
        step(L_GREEN, 1'b1, 1'b0, 1'b0);
        check_val("short_pulse", err_pulse, 1);
        check_val("short_code", err_code, 4);
        check_val("short_flags", err_flags, 4'b1000);
        check_val("short_phase", phase, 2);
        step(L_GREEN, 1'b1, 1'b0, 1'b0);
        check_val("pulse_one_cycle", err_pulse, 0);

        // Onehot in RUN, then resync
        step(3'b110, 1'b1, 1'b0, 1'b0);
        check_val("onehot_code", err_code, 1);
        check_val("onehot_flags", err_flags, 4'b1001);
        check_val("onehot_unlock", {phase, locked}, 0);
        step(L_RED, 1'b1, 1'b0, 1'b0);
        check_val("relock", locked, 1);
        check_val("sticky_flags", err_flags, 4'b1001);

        // Order violation RED -> YELLOW
        drive_n(L_RED, 1'b1, 7);
        step(L_YELLOW, 1'b1, 1'b0, 1'b0);
        check_val("order_code", err_code, 3);
        check_val("order_flag", err_flags[2], 1);

        // Hold violation: phase change with enable low
        do_reset();
        drive_n(L_RED, 1'b1, 8);
        step(L_GREEN, 1'b0, 1'b0, 1'b0);
        check_val("hold_code", err_code, 2);
        check_val("hold_flags", err_flags, 4'b0010);

        // Long GREEN -> one dwell_long on the 9th enabled sample
        do_reset();
        drive_n(L_RED, 1'b1, 8);
        pulse_cnt = 0;
        drive_n(L_GREEN, 1'b1, 8);
        step(L_GREEN, 1'b1, 1'b0, 1'b0);
        check_val("long_pulse", err_pulse, 1);
        check_val("long_code", err_code, 5);
        drive_n(L_GREEN, 1'b1, 3);
        check_val("long_once", pulse_cnt, 1);

        // Enable low mid-GREEN freezes dwell
        do_reset();
        drive_n(L_RED, 1'b1, 8);
        drive_n(L_GREEN, 1'b1, 4);
        drive_n(L_GREEN, 1'b0, 20);
        drive_n(L_GREEN, 1'b1, 4);
        step(L_YELLOW, 1'b1, 1'b0, 1'b0);
        check_val("frozen_no_err", err_flags, 0);

        // clr_err on the same edge as a onehot violation
        step(L_RED, 1'b1, 1'b0, 1'b0);
        check_val("pre_clr_flags", err_flags, 4'b1000);
        step(3'b011, 1'b1, 1'b1, 1'b0);
        check_val("clr_vs_onehot", {err_flags, err_code}, {4'b0001, 3'd1});

        // Reset mid-YELLOW clears everything, including cycles_done
        drive_n(L_RED, 1'b1, 8);
        drive_n(L_GREEN, 1'b1, 8);
        drive_n(L_YELLOW, 1'b1, 3);
        step(L_RED, 1'b1, 1'b0, 1'b0);
        check_val("cycle_before_rst", cycles_done, 1);
        drive_n(L_RED, 1'b1, 7);
        drive_n(L_GREEN, 1'b1, 8);
        drive_n(L_YELLOW, 1'b1, 2);
        step(L_YELLOW, 1'b1, 1'b0, 1'b1);
        check_val("rst_mid_yellow", {phase, locked, err_pulse, err_flags, err_code, cycles_done}, 0);

        // cycles_done wraps after 256 legal cycles
        do_reset();
        drive_n(L_RED, 1'b1, 8);
        for (int k = 0; k < 257; k++) begin
            drive_n(L_GREEN, 1'b1, 8);
            drive_n(L_YELLOW, 1'b1, 3);
            drive_n(L_RED, 1'b1, 8);
        end
        check_val("cycles_wrap", cycles_done, 1);
        check_val("wrap_no_err", err_flags, 0);

        // Random traffic: mostly plausible sequences with timing jitter and faults
        do_reset();
        cur_l  = L_RED;
        remain = RED_N;
        for (int i = 0; i < 3000; i++) begin
            ren  = ($urandom_range(0, 7) != 0);
            rclr = ($urandom_range(0, 19) == 0);
            rrst = ($urandom_range(0, 399) == 0);
            rl   = cur_l;
            pick = $urandom_range(0, 99);
            if (pick < 3) begin
                rl = 3'($urandom_range(0, 7));
            end else if (remain <= 0 && (ren || pick < 6)) begin
                if (pick < 10) begin
                    case ($urandom_range(0, 2))
                        0:       cur_l = L_RED;
                        1:       cur_l = L_GREEN;
                        default: cur_l = L_YELLOW;
                    endcase
                end else begin
                    cur_l = succ_l(cur_l);
                end
                rl     = cur_l;
                remain = lim_l(cur_l) + $urandom_range(0, 4) - 2;
            end
            step(rl, ren, rclr, rrst);
            if (ren && rl == cur_l) remain--;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
